// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
//   op_t      : operation encodings seen on the op bus and the slice op bus
//   state_t   : sequencer FSM states
//   DEFAULT_WIDTH : default operand/result width
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SLT = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

endpackage

// File: rtl/serial_alu_seq_if.sv
// Host-side handshake/bus bundle of the serial ALU sequencer.
//   slave  : sequencer side (takes request + operands, returns result/flags)
//   master : requester side
interface serial_alu_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       op;
  logic             A_invert;
  logic             B_invert;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport slave (
    input  start, A, B, op, A_invert, B_invert, carry_in,
    output busy, done, result, carry_out, overflow, zero
  );

  modport master (
    output start, A, B, op, A_invert, B_invert, carry_in,
    input  busy, done, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/serial_shift_reg.sv
// Parallel-load, right-shift register with serial input at the MSB.
//   load/load_val : parallel load (priority over shift)
//   shift/ser_in  : shift right by one, ser_in enters at the MSB
//   q             : current contents
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (load)       q_d = load_val;
    else if (shift) q_d = {ser_in, q_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer driving an external 1-bit ALU slice.
//   clk, rst_n : clock, async active-low reset
//   bus        : start/operands in, busy/done/result/flags out
//   slice_*    : one operand bit pair per RUN cycle to the slice (LSB first),
//                slice_result/slice_carry come back from it
// done pulses WIDTH+1 cycles after the accepting edge; result/flags are
// registered on the DONE->IDLE edge and hold until the next completion.
module serial_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_alu_seq_if.slave        bus,
  output logic                   slice_A,
  output logic                   slice_B,
  output logic                   slice_A_invert,
  output logic                   slice_B_invert,
  output logic                   slice_carry_in,
  output logic                   slice_Less,
  output logic [1:0]             slice_op,
  input  logic                   slice_result,
  input  logic                   slice_carry
);
  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic             a_inv_q, a_inv_d, b_inv_q, b_inv_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cin_msb_q, cin_msb_d, sum_msb_q, sum_msb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d, overflow_q, overflow_d;
  logic             zero_q, zero_d, done_q, done_d;

  logic             load, shift;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             ovf, is_arith;
  logic [WIDTH-1:0] final_res;
  logic             unused_sr_bits;

  serial_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(bus.A),
    .shift(shift), .ser_in(1'b0), .q(a_sr)
  );
  serial_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(bus.B),
    .shift(shift), .ser_in(1'b0), .q(b_sr)
  );
  serial_shift_reg #(.WIDTH(WIDTH)) u_res_sr (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val('0),
    .shift(shift), .ser_in(slice_result), .q(res_sr)
  );

  // Only the LSB of each operand register feeds the slice.
  assign unused_sr_bits = ^{a_sr[WIDTH-1:1], b_sr[WIDTH-1:1]};

  // Flag evaluation while in DONE: carry_q now holds the carry out of the MSB.
  always_comb begin
    is_arith  = op_q[1];
    ovf       = cin_msb_q ^ carry_q;
    final_res = (op_q == OP_SLT) ? WIDTH'(sum_msb_q ^ ovf) : res_sr;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_inv_d     = a_inv_q;
    b_inv_d     = b_inv_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    cin_msb_d   = cin_msb_q;
    sum_msb_d   = sum_msb_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    done_d      = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load  = 1'b1;
          op_d  = op_t'(bus.op);
          cnt_d = '0;
          if (op_t'(bus.op) == OP_SLT) begin
            // SLT runs as A - B through the slice
            a_inv_d = 1'b0;
            b_inv_d = 1'b1;
            carry_d = 1'b1;
          end else begin
            a_inv_d = bus.A_invert;
            b_inv_d = bus.B_invert;
            carry_d = bus.carry_in;
          end
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        shift   = 1'b1;
        carry_d = slice_carry;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          cin_msb_d = carry_q;
          sum_msb_d = slice_result;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        result_d    = final_res;
        carry_out_d = is_arith & carry_q;
        overflow_d  = is_arith & ovf;
        zero_d      = (final_res == '0);
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_AND;
      a_inv_q     <= 1'b0;
      b_inv_q     <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      cin_msb_q   <= 1'b0;
      sum_msb_q   <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_inv_q     <= a_inv_d;
      b_inv_q     <= b_inv_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      cin_msb_q   <= cin_msb_d;
      sum_msb_q   <= sum_msb_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

  assign slice_A        = (state_q == S_RUN) & a_sr[0];
  assign slice_B        = (state_q == S_RUN) & b_sr[0];
  assign slice_carry_in = (state_q == S_RUN) & carry_q;
  assign slice_A_invert = a_inv_q;
  assign slice_B_invert = b_inv_q;
  assign slice_Less     = 1'b0;
  assign slice_op       = (op_q == OP_SLT) ? OP_ADD : op_q;
endmodule

// File: tb/tb_serial_alu_seq.sv
module tb_serial_alu_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_alu_seq_if #(.WIDTH(W)) bus ();

  logic       slice_A, slice_B, slice_A_invert, slice_B_invert;
  logic       slice_carry_in, slice_Less, slice_result, slice_carry;
  logic [1:0] slice_op;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .slice_A(slice_A), .slice_B(slice_B),
    .slice_A_invert(slice_A_invert), .slice_B_invert(slice_B_invert),
    .slice_carry_in(slice_carry_in), .slice_Less(slice_Less),
    .slice_op(slice_op), .slice_result(slice_result), .slice_carry(slice_carry)
  );

  // 1-bit ALU slice model
  logic sa, sb;
  always_comb begin
    sa = slice_A ^ slice_A_invert;
    sb = slice_B ^ slice_B_invert;
    slice_carry = (sa & sb) | (sa & slice_carry_in) | (sb & slice_carry_in);
    case (slice_op)
      2'b00:   slice_result = sa & sb;
      2'b01:   slice_result = sa | sb;
      2'b10:   slice_result = sa ^ sb ^ slice_carry_in;
      default: slice_result = slice_Less;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o,
                       input logic ai, input logic bi, input logic ci);
    bus.A = a; bus.B = b; bus.op = o;
    bus.A_invert = ai; bus.B_invert = bi; bus.carry_in = ci;
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] o, input logic ai, input logic bi, input logic ci,
                        input logic [7:0] e_res, input logic e_co, input logic e_ov,
                        input logic e_z);
    int n, busy_cnt;
    @(negedge clk);
    drive(a, b, o, ai, bi, ci);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy_cnt = bus.busy ? 1 : 0;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin n = i; break; end
    end
    check({tag, ".latency"}, 32'(n), 32'(W + 1));
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(W));
    check({tag, ".result"}, 32'(bus.result), 32'(e_res));
    check({tag, ".carry_out"}, 32'(bus.carry_out), 32'(e_co));
    check({tag, ".overflow"}, 32'(bus.overflow), 32'(e_ov));
    check({tag, ".zero"}, 32'(bus.zero), 32'(e_z));
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, ".result_hold"}, 32'(bus.result), 32'(e_res));
  endtask

  initial begin
    int n_done, first, second, cyc;
    bus.start = 1'b0;
    drive(8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Reset state
    #12;
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.result", 32'(bus.result), 32'd0);
    check("rst.flags", 32'({bus.carry_out, bus.overflow, bus.zero}), 32'd0);
    check("rst.slice", 32'({slice_A, slice_B, slice_carry_in, slice_Less, slice_op}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Arithmetic
    run_op("add",     8'h35, 8'h4A, 2'b10, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0);
    run_op("add_ovf", 8'h7F, 8'h01, 2'b10, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("sub",     8'h10, 8'h20, 2'b10, 1'b0, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);

    // SLT (inversion/carry inputs deliberately set to be ignored)
    run_op("slt_5_9",  8'h05, 8'h09, 2'b11, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
    check("slt.slice_op", 32'(slice_op), 32'h2);
    check("slt.slice_inv", 32'({slice_A_invert, slice_B_invert}), 32'h1);
    check("slt.slice_cin_idle", 32'(slice_carry_in), 32'd0);
    run_op("slt_ff_1", 8'hFF, 8'h01, 2'b11, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
    run_op("slt_80_7f", 8'h80, 8'h7F, 2'b11, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0);
    run_op("slt_9_5",  8'h09, 8'h05, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Logic with both inversions: NOR / NAND
    run_op("nor",  8'h0F, 8'h33, 2'b00, 1'b1, 1'b1, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
    run_op("nand", 8'h0F, 8'h33, 2'b01, 1'b1, 1'b1, 1'b1, 8'hFC, 1'b0, 1'b0, 1'b0);

    // start pulsed while running is ignored
    @(negedge clk);
    drive(8'h35, 8'h4A, 2'b10, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_done = 0; first = 0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        n_done++;
        if (first == 0) first = i;
      end
      bus.start = (i == 3);
    end
    check("ign.done_count", 32'(n_done), 32'd1);
    check("ign.latency", 32'(first), 32'(W + 1));
    check("ign.result", 32'(bus.result), 32'h7F);

    // start held high: back-to-back every W+2 cycles
    @(negedge clk);
    drive(8'h01, 8'h02, 2'b10, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    first = -1; second = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (first < 0) first = i;
        else begin second = i; break; end
      end
    end
    bus.start = 1'b0;
    check("b2b.spacing", 32'(second - first), 32'(W + 2));
    check("b2b.result", 32'(bus.result), 32'h03);
    repeat (3) @(posedge clk);

    // Reset in the middle of an operation
    @(negedge clk);
    drive(8'h35, 8'h4A, 2'b10, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid.busy", 32'(bus.busy), 32'd1);
    check("mid.slice_ab", 32'({slice_A, slice_B}), 32'h1);
    check("mid.slice_cin", 32'(slice_carry_in), 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst.busy", 32'(bus.busy), 32'd0);
    check("arst.done", 32'(bus.done), 32'd0);
    check("arst.result", 32'(bus.result), 32'd0);
    check("arst.flags", 32'({bus.carry_out, bus.overflow, bus.zero}), 32'd0);
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) cyc++;
    end
    check("arst.no_done", 32'(cyc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 8'h12, 8'h34, 2'b10, 1'b0, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
